// File: rtl/demux1_2_4bit.sv
`default_nettype none
// ============================================================================
// Module   : demux1_2_4bit
// Purpose  : Registered 1-to-2 demultiplexer with an independent one-entry
//            valid/ready holding register per output (A when selection=1,
//            B when selection=0). Optional macro DEMUX_STATS_EN adds
//            per-output drain counters; otherwise a_count/b_count are 0.
// Revision : 1.0 - initial release
// ============================================================================
module demux1_2_4bit #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 selection,
    output logic [WIDTH-1:0]     a_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [CNT_WIDTH-1:0] a_count,
    output logic [CNT_WIDTH-1:0] b_count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [1:0] w_out_ready;
    logic       w_sel_open;
    logic       w_accept;

    assign w_out_ready = {b_ready, a_ready};

    // Only the selected side gates acceptance; the other side may be stalled.
    assign w_sel_open = selection ? (!a_valid || a_ready) : (!b_valid || b_ready);
    assign in_ready   = reset_n && w_sel_open;
    assign w_accept   = in_valid && in_ready;

    // Index 0 is output A (selection=1), index 1 is output B (selection=0).
    for (genvar gi = 0; gi < 2; gi++) begin : g_out
        logic [0:0]       r_state;
        logic [WIDTH-1:0] r_data;
        logic             w_load;
        logic             w_drain;

        assign w_load  = w_accept && (selection == (gi == 0));
        assign w_drain = (r_state == FULL) && w_out_ready[gi];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= EMPTY;
                r_data  <= '0;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_load) begin
                            r_state <= FULL;
                            r_data  <= in_data;
                        end
                    end
                    FULL: begin
                        if (w_load) begin
                            r_data <= in_data;
                        end else if (w_drain) begin
                            r_state <= EMPTY;
                        end
                    end
                    default: r_state <= EMPTY;
                endcase
            end
        end

`ifdef DEMUX_STATS_EN
        logic [CNT_WIDTH-1:0] r_count;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_count <= '0;
            end else if (w_drain) begin
                r_count <= r_count + 1'b1;
            end
        end
`endif
    end

    assign a_data  = g_out[0].r_data;
    assign a_valid = (g_out[0].r_state == FULL);
    assign b_data  = g_out[1].r_data;
    assign b_valid = (g_out[1].r_state == FULL);

`ifdef DEMUX_STATS_EN
    assign a_count = g_out[0].r_count;
    assign b_count = g_out[1].r_count;
`else
    assign a_count = '0;
    assign b_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux1_2_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1_2_4bit
// Purpose  : Directed self-checking bench for demux1_2_4bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux1_2_4bit;

    localparam int WIDTH     = 4;
    localparam int CNT_WIDTH = 8;

    logic                 clk;
    logic                 reset_n;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 selection;
    logic [WIDTH-1:0]     a_data;
    logic                 a_valid;
    logic                 a_ready;
    logic [WIDTH-1:0]     b_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [CNT_WIDTH-1:0] a_count;
    logic [CNT_WIDTH-1:0] b_count;

    int n_checks;
    int n_fail;

    demux1_2_4bit #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .selection (selection),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .a_count   (a_count),
        .b_count   (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        selection = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;

        // Reset state
        #3 reset_n = 1'b0;
        #1;
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a_data", a_data, 0);
        check("rst_b_data", b_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_a_count", a_count, 0);
        check("rst_b_count", b_count, 0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // Steering
        in_data = 4'hA; selection = 1'b1; in_valid = 1'b1; a_ready = 1'b1;
        #1 check("steer_a_in_ready", in_ready, 1);
        step();
        check("steer_a_data", a_data, 4'hA);
        check("steer_a_valid", a_valid, 1);
        check("steer_a_b_valid", b_valid, 0);
        in_data = 4'h5; selection = 1'b0;
        step();
        check("steer_b_data", b_data, 4'h5);
        check("steer_b_valid", b_valid, 1);
        check("steer_a_hold", a_data, 4'hA);
        check("steer_a_drained", a_valid, 0);
        in_valid = 1'b0; b_ready = 1'b1;
        step();
        check("steer_b_drained", b_valid, 0);

        // Backpressure on A, then divert to B
        a_ready = 1'b0; b_ready = 1'b0;
        in_data = 4'h3; selection = 1'b1; in_valid = 1'b1;
        step();
        in_data = 4'h9;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_a_data", a_data, 4'h3);
            check("bp_a_valid", a_valid, 1);
            step();
        end
        selection = 1'b0;
        #1 check("bp_switch_in_ready", in_ready, 1);
        step();
        check("bp_b_data", b_data, 4'h9);
        check("bp_b_valid", b_valid, 1);
        check("bp_a_still", a_data, 4'h3);
        in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        step();
        check("bp_a_empty", a_valid, 0);
        check("bp_b_empty", b_valid, 0);

        // Streaming 0..F on A
        selection = 1'b1; in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_data = WIDTH'(i);
            #1 check("stream_in_ready", in_ready, 1);
            step();
            check("stream_a_data", a_data, i);
            check("stream_a_valid", a_valid, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_a_empty", a_valid, 0);

        // Both full, both drain, B reloads with 7
        a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
        in_data = 4'h1; selection = 1'b1;
        step();
        in_data = 4'h2; selection = 1'b0;
        step();
        check("sim_a_full", a_valid, 1);
        check("sim_b_full", b_valid, 1);
        a_ready = 1'b1; b_ready = 1'b1; in_data = 4'h7; selection = 1'b0;
        step();
        check("sim_a_valid", a_valid, 0);
        check("sim_a_hold", a_data, 4'h1);
        check("sim_b_valid", b_valid, 1);
        check("sim_b_data", b_data, 4'h7);

        // No accept while in_valid=0
        in_valid = 1'b0; selection = 1'b1; in_data = 4'hF;
        step();
        check("noacc_a_valid", a_valid, 0);
        check("noacc_b_valid", b_valid, 0);
        check("noacc_a_data", a_data, 4'h1);
        check("noacc_b_data", b_data, 4'h7);

        // Asynchronous reset mid-transfer
        a_ready = 1'b0; in_valid = 1'b1; in_data = 4'hC; selection = 1'b1;
        step();
        check("arst_pre_a_valid", a_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_a_valid", a_valid, 0);
        check("arst_b_valid", b_valid, 0);
        check("arst_a_data", a_data, 0);
        check("arst_b_data", b_data, 0);
        check("arst_in_ready", in_ready, 0);
        step();
        in_valid = 1'b0;
        reset_n = 1'b1;
        #1 check("arst_rel_in_ready", in_ready, 1);

        // 257 drains on A: counter wraps to 1 with stats, stays 0 without
        a_ready = 1'b1; selection = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = WIDTH'(i);
            step();
        end
        in_valid = 1'b0;
        step();
`ifdef DEMUX_STATS_EN
        check("stats_a_count", a_count, 1);
`else
        check("stats_a_count", a_count, 0);
`endif
        check("stats_b_count", b_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
